port_out_uart_tx: RTL and testbench
===================================

Name: port_out_uart_tx

Overview:
- Downstream consumer of the CPU's output port: each OUT instruction pushes one byte into a small FIFO.
- The byte is then serialized as 8N1 UART frames on a single tx pin.
- Decouples the single-cycle-per-instruction CPU from the slow serial line.
- Reports full/overflow status so software or the bench can detect dropped bytes.

Parameters:
- DATA_BITS, 8, width of the byte accepted from the CPU output port.
- FIFO_DEPTH, 4, number of buffered bytes; power of two, at least 2.
- CLKS_PER_BIT, 16, clock cycles per serial bit; at least 2.

Ports:
- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  one-cycle strobe; high in the cycle the CPU executes OUT.
- wr_data  input  DATA_BITS  byte to transmit; sampled with wr_en.
- tx  output  1  serial line; idle high.
- busy  output  1  high while a frame is in progress (state != IDLE).
- fifo_full  output  1  fifo_count == FIFO_DEPTH.
- fifo_count  output  $clog2(FIFO_DEPTH+1)  bytes currently buffered, excluding the frame in progress.
- overflow  output  1  sticky; set when a write is dropped, cleared only by reset.

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-high.
- Reset values: tx=1, busy=0, fifo_count=0, fifo_full=0, overflow=0, state=IDLE, FIFO pointers=0, bit and baud counters=0.
- Reset mid-frame aborts the frame: tx=1 after that edge, FIFO contents discarded.
- Push: wr_en sampled at edge N.
  - Accepted iff fifo_count (pre-edge value) < FIFO_DEPTH.
  - Full is judged on the pre-edge count, so a same-edge pop does NOT make room.
  - A write while full is dropped and sets overflow at edge N.
- Pointers: wrap modulo FIFO_DEPTH.
- fifo_count update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: tx=1. If fifo_count>0, pop the head into the shift register and go to START; baud counter=0.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
- DATA: tx=shift[0], LSB first.
  - Each bit is held CLKS_PER_BIT cycles, then shift right.
  - After bit DATA_BITS-1, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles.
  - At the end, if fifo_count>0, pop and go directly to START (zero-gap back-to-back frames).
  - Otherwise go to IDLE.
- Latency:
  - wr_en at edge N into an empty, idle block: fifo_count=1 after N; pop at edge N+1.
  - tx falls after edge N+1.
  - One frame = (DATA_BITS+2)*CLKS_PER_BIT cycles.
  - busy falls on the edge that ends STOP with an empty FIFO.
- tx is driven from a register (glitch-free); busy and fifo_full are derived combinationally from registered state.

Decomposition:
- Shared package (alongside the existing defines):
  - tx_state_t enum {IDLE, START, DATA, STOP}.
  - Default FIFO_DEPTH and CLKS_PER_BIT constants.
- One natural sub-module: sync_fifo (parameterised width/depth).
  - Signals: push/pop, full, empty, count.
  - Implements the pre-edge full rule.
- The FSM, baud counter, bit counter and shift register stay in port_out_uart_tx.

Test Plan:
- Reset, all parameters at default except CLKS_PER_BIT=4 (all tests):
  -> tx=1, busy=0, fifo_count=0, overflow=0 on the edge after reset.
- Single write wr_data=0xA5 at edge N:
  -> tx low after N+1 for 4 cycles.
  -> Data bits 1,0,1,0,0,1,0,1, each 4 cycles.
  -> Stop bit high 4 cycles.
  -> busy high for exactly 40 cycles.
- Writes 0x01, 0x02, 0x03 on three consecutive edges:
  -> three contiguous frames with no idle cycle between stop and next start.
  -> busy high for 120 cycles.
  -> fifo_count peaks at 2.
- Write 0x55, then 5 further writes while the first frame is in progress:
  -> 4 accepted, fifo_full=1, 5th dropped, overflow=1.
  -> Transmitted order matches the accepted order.
  -> overflow stays 1 after the FIFO drains.
- With the FIFO full, a wr_en on the exact edge the STOP→START pop occurs:
  -> write dropped, overflow=1, fifo_count goes 4→3.
- Assert reset during DATA bit 3 of 0xFF with 2 bytes queued:
  -> tx=1, busy=0, fifo_count=0, overflow=0 after that edge.
  -> No further frames until a new write.

Source files
------------

// File: rtl/port_out_uart_tx_pkg.sv
// Shared types and default sizing for the output-port UART transmitter.
package port_out_uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int DEF_DATA_BITS    = 8;
  localparam int DEF_FIFO_DEPTH   = 4;
  localparam int DEF_CLKS_PER_BIT = 16;

endpackage

// File: rtl/port_out_uart_tx_sync_fifo.sv
// Small synchronous FIFO; full is judged on the pre-edge count, so a same-edge pop never makes room.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Power-of-two depth lets the pointers wrap naturally.
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/port_out_uart_tx.sv
// CPU output-port byte FIFO feeding an 8N1 UART serializer with zero-gap back-to-back frames.
module port_out_uart_tx
  import port_out_uart_tx_pkg::*;
#(
  parameter int DATA_BITS    = DEF_DATA_BITS,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            wr_en,
  input  logic [DATA_BITS-1:0]            wr_data,
  output logic                            tx,
  output logic                            busy,
  output logic                            fifo_full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            overflow
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  tx_state_t            state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 overflow_q, overflow_d;
  logic                 pop;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 baud_done;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock_i (clock),
    .reset_i (reset),
    .push_i  (wr_en),
    .wdata_i (wr_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign baud_done  = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign overflow_d = overflow_q | (wr_en & fifo_full);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          baud_d  = '0;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_d = '0;
          // Pop straight into the next start bit so queued frames leave no idle gap.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rdata;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != IDLE);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_port_out_uart_tx.sv
// Directed bench for port_out_uart_tx with CLKS_PER_BIT=4 (40-cycle frames).
module tb_port_out_uart_tx;

  logic       clock;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       tx;
  logic       busy;
  logic       fifo_full;
  logic [2:0] fifo_count;
  logic       overflow;

  int errors = 0;
  int checks = 0;
  logic [2:0] peak;

  port_out_uart_tx #(
    .DATA_BITS    (8),
    .FIFO_DEPTH   (4),
    .CLKS_PER_BIT (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .tx         (tx),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (fifo_count > peak) peak = fifo_count;

  // Expected tx per cycle over one frame: start, 8 data bits LSB first, stop; 4 cycles each.
  function automatic logic [39:0] expand_frame(input logic [7:0] d);
    logic [9:0]  b;
    logic [39:0] r;
    b = {1'b1, d, 1'b0};
    for (int i = 0; i < 40; i++) r[i] = b[i/4];
    return r;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push_byte(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(posedge clock);
    #1;
    wr_en   = 1'b0;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    step(2);
    reset   = 1'b0;
  endtask

  task automatic capture_frame(output logic [39:0] txs, output logic [39:0] bsy);
    for (int i = 0; i < 40; i++) begin
      txs[i] = tx;
      bsy[i] = busy;
      step(1);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", fifo_full); end
  endtask

  task automatic test_single();
    logic [39:0] txs, bsy;
    do_reset();
    push_byte(8'hA5);
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count_after_push: got %0d expected 1", fifo_count); end
    checks++; if (busy !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL single_idle_after_push: got busy=%b tx=%b expected busy=0 tx=1", busy, tx); end
    step(1);
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL single_count_after_pop: got %0d expected 0", fifo_count); end
    capture_frame(txs, bsy);
    checks++; if (txs !== expand_frame(8'hA5)) begin errors++; $display("FAIL single_frame: got %h expected %h", txs, expand_frame(8'hA5)); end
    checks++; if (bsy !== {40{1'b1}}) begin errors++; $display("FAIL single_busy: got %h expected %h", bsy, {40{1'b1}}); end
    checks++; if (busy !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL single_end: got busy=%b tx=%b expected busy=0 tx=1", busy, tx); end
  endtask

  task automatic test_back_to_back();
    logic [39:0] txs, bsy;
    logic [7:0]  d;
    do_reset();
    peak    = 3'd0;
    wr_en   = 1'b1;
    wr_data = 8'h01;
    step(1);
    wr_data = 8'h02;
    step(1);
    wr_data = 8'h03;
    fork
      begin
        @(posedge clock);
        #1;
        wr_en = 1'b0;
      end
    join_none
    for (int f = 0; f < 3; f++) begin
      d = 8'(f + 1);
      capture_frame(txs, bsy);
      checks++; if (txs !== expand_frame(d)) begin errors++; $display("FAIL b2b_frame%0d: got %h expected %h", f, txs, expand_frame(d)); end
      checks++; if (bsy !== {40{1'b1}}) begin errors++; $display("FAIL b2b_busy%0d: got %h expected %h", f, bsy, {40{1'b1}}); end
    end
    checks++; if (busy !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL b2b_end: got busy=%b tx=%b expected busy=0 tx=1", busy, tx); end
    checks++; if (peak !== 3'd2) begin errors++; $display("FAIL b2b_peak: got %0d expected 2", peak); end
  endtask

  task automatic test_overflow();
    logic [39:0] txs, bsy;
    logic [7:0]  d;
    do_reset();
    push_byte(8'h55);
    step(1);
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          wr_en   = 1'b1;
          wr_data = 8'(8'h10 + i);
          @(posedge clock);
          #1;
        end
        wr_en = 1'b0;
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", fifo_full); end
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", fifo_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
      end
    join_none
    capture_frame(txs, bsy);
    checks++; if (txs !== expand_frame(8'h55)) begin errors++; $display("FAIL ovf_frame55: got %h expected %h", txs, expand_frame(8'h55)); end
    for (int f = 0; f < 4; f++) begin
      d = 8'(8'h10 + f);
      capture_frame(txs, bsy);
      checks++; if (txs !== expand_frame(d)) begin errors++; $display("FAIL ovf_frame%0d: got %h expected %h", f, txs, expand_frame(d)); end
    end
    checks++; if (busy !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL ovf_drained: got busy=%b count=%0d expected busy=0 count=0", busy, fifo_count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_full_pop_edge();
    logic [39:0] txs, bsy;
    logic [7:0]  d;
    do_reset();
    push_byte(8'h80);
    step(1);
    for (int i = 1; i <= 4; i++) push_byte(8'(8'h80 + i));
    checks++; if (fifo_count !== 3'd4 || fifo_full !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL edge_filled: got count=%0d full=%b ovf=%b expected 4 1 0", fifo_count, fifo_full, overflow); end
    step(35);
    push_byte(8'h77);
    checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL edge_count: got %0d expected 3", fifo_count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL edge_overflow: got %b expected 1", overflow); end
    checks++; if (fifo_full !== 1'b0 || tx !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL edge_restart: got full=%b tx=%b busy=%b expected 0 0 1", fifo_full, tx, busy); end
    for (int f = 1; f <= 4; f++) begin
      d = 8'(8'h80 + f);
      capture_frame(txs, bsy);
      checks++; if (txs !== expand_frame(d)) begin errors++; $display("FAIL edge_frame%0d: got %h expected %h", f, txs, expand_frame(d)); end
    end
    checks++; if (busy !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL edge_end: got busy=%b tx=%b expected busy=0 tx=1", busy, tx); end
  endtask

  task automatic test_reset_mid_frame();
    logic [39:0] txs, bsy;
    int bad;
    do_reset();
    push_byte(8'hFF);
    push_byte(8'hAA);
    push_byte(8'hBB);
    checks++; if (fifo_count !== 3'd2) begin errors++; $display("FAIL midrst_queued: got %0d expected 2", fifo_count); end
    step(16);
    checks++; if (tx !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL midrst_in_data: got tx=%b busy=%b expected 1 1", tx, busy); end
    reset = 1'b1;
    step(1);
    checks++; if (tx !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL midrst_line: got tx=%b busy=%b expected 1 0", tx, busy); end
    checks++; if (fifo_count !== 3'd0 || overflow !== 1'b0 || fifo_full !== 1'b0) begin errors++; $display("FAIL midrst_fifo: got count=%0d ovf=%b full=%b expected 0 0 0", fifo_count, overflow, fifo_full); end
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
      step(1);
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL midrst_quiet: got %0d active cycles expected 0", bad); end
    push_byte(8'h3C);
    step(1);
    capture_frame(txs, bsy);
    checks++; if (txs !== expand_frame(8'h3C)) begin errors++; $display("FAIL midrst_new_frame: got %h expected %h", txs, expand_frame(8'h3C)); end
  endtask

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    peak    = 3'd0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_full_pop_edge();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
